decay_timer_ctrl: RTL

- Sequences a single muon-lifetime measurement from the coincidence and decay pulse streams.
- The start input is a coincidence (muon stop) pulse. From that point the block times the interval to the next valid decay pulse.
- It rejects afterpulses, aborts on window timeout and enforces a post-event dead time.
- Each measured interval is delivered to the downstream histogram/UART logic over a valid/ready handshake.

---
 rtl/decay_timer_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/decay_timer_ctrl.sv
// ---------------------------------------------------------------------------
// decay_timer_ctrl
//
// Sequences one muon-lifetime measurement at a time. A coincidence pulse
// (start_pulse) opens a measurement. The first decay candidate (stop_pulse)
// that arrives at least MIN_GAP cycles later closes it. The measured interval
// is then offered downstream over a valid/ready handshake. A measurement that
// reaches WINDOW cycles without an accepted stop is counted as a timeout.
// Every completed event (reported or timed out) is followed by DEADTIME
// cycles of dead time before the block re-arms.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         run enable (level); dropping it aborts a measurement
//   start_pulse    one-cycle coincidence pulse (muon stop)
//   stop_pulse     one-cycle decay-candidate pulse
//   result_valid   measured interval available
//   result_ready   consumer accepts result
//   result_time    measured interval in clk cycles
//   busy           high whenever the controller is not IDLE
//   state_dbg      IDLE=0, MEASURE=1, REPORT=2, DEAD=3
//   decay_count    accepted decays, saturating
//   timeout_count  window timeouts, saturating
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module decay_timer_ctrl #(
   parameter int CNT_W    = 16,
   parameter int WINDOW   = 20000,
   parameter int MIN_GAP  = 4,
   parameter int DEADTIME = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             start_pulse,
   input  logic             stop_pulse,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [CNT_W-1:0] result_time,
   output logic             busy,
   output logic [1:0]       state_dbg,
   output logic [CNT_W-1:0] decay_count,
   output logic [CNT_W-1:0] timeout_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      REPORT  = 2'd2,
      DEAD    = 2'd3
   } state_t;

   // The dead-time counter is separate from the interval timer so that
   // DEADTIME is not limited by CNT_W.
   localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

   localparam logic [CNT_W-1:0]  WINDOW_C  = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0]  MIN_GAP_C = CNT_W'(MIN_GAP);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

   state_t            state_reg,         state_next;
   logic [CNT_W-1:0]  timer_reg,         timer_next;
   logic [DEAD_W-1:0] dead_cnt_reg,      dead_cnt_next;
   logic [CNT_W-1:0]  result_time_reg,   result_time_next;
   logic              result_valid_reg,  result_valid_next;
   logic [CNT_W-1:0]  decay_count_reg,   decay_count_next;
   logic [CNT_W-1:0]  timeout_count_reg, timeout_count_next;
   logic              busy_reg,          busy_next;

   // k: the interval value for the current MEASURE cycle. It never exceeds
   // WINDOW, so it cannot wrap.
   logic [CNT_W-1:0]  timer_inc;
   assign timer_inc = timer_reg + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         timer_reg         <= '0;
         dead_cnt_reg      <= '0;
         result_time_reg   <= '0;
         result_valid_reg  <= 1'b0;
         decay_count_reg   <= '0;
         timeout_count_reg <= '0;
         busy_reg          <= 1'b0;
      end else begin
         state_reg         <= state_next;
         timer_reg         <= timer_next;
         dead_cnt_reg      <= dead_cnt_next;
         result_time_reg   <= result_time_next;
         result_valid_reg  <= result_valid_next;
         decay_count_reg   <= decay_count_next;
         timeout_count_reg <= timeout_count_next;
         busy_reg          <= busy_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      timer_next         = timer_reg;
      dead_cnt_next      = dead_cnt_reg;
      result_time_next   = result_time_reg;
      result_valid_next  = result_valid_reg;
      decay_count_next   = decay_count_reg;
      timeout_count_next = timeout_count_reg;

      case (state_reg)
         IDLE: begin
            // stop_pulse is ignored here; a simultaneous start still arms.
            if (start_pulse && enable) begin
               state_next = MEASURE;
               timer_next = '0;
            end
         end

         MEASURE: begin
            timer_next = timer_inc;
            if (!enable) begin
               state_next = IDLE;
            end else if (stop_pulse && (timer_inc >= MIN_GAP_C)) begin
               // A stop exactly at WINDOW is a valid decay and wins over
               // the timeout.
               result_time_next  = timer_inc;
               result_valid_next = 1'b1;
               if (decay_count_reg != CNT_MAX) begin
                  decay_count_next = decay_count_reg + CNT_W'(1);
               end
               state_next = REPORT;
            end else if (timer_inc == WINDOW_C) begin
               if (timeout_count_reg != CNT_MAX) begin
                  timeout_count_next = timeout_count_reg + CNT_W'(1);
               end
               state_next    = DEAD;
               timer_next    = '0;
               dead_cnt_next = '0;
            end
         end

         REPORT: begin
            // result_valid is high throughout REPORT, so ready alone
            // completes the transfer.
            if (result_ready) begin
               result_valid_next = 1'b0;
               state_next        = DEAD;
               timer_next        = '0;
               dead_cnt_next     = '0;
            end
         end

         DEAD: begin
            // The first DEAD cycle has dead_cnt = 0. Leaving on count
            // DEADTIME-1 therefore gives exactly DEADTIME DEAD cycles.
            if (dead_cnt_reg == DEAD_LAST) begin
               state_next = IDLE;
            end else begin
               dead_cnt_next = dead_cnt_reg + DEAD_W'(1);
            end
         end

         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   assign result_valid  = result_valid_reg;
   assign result_time   = result_time_reg;
   assign busy          = busy_reg;
   assign state_dbg     = state_reg;
   assign decay_count   = decay_count_reg;
   assign timeout_count = timeout_count_reg;

endmodule
